// File: rtl/cheer_pkg.sv
// Shared definitions for the tug-of-war victory cheer path.
package cheer_pkg;

  // Default width of the score and LED bank.
  localparam int CHEER_LED_W = 7;

  // Cheer FSM state encoding.
  typedef enum logic {
    CHEER_IDLE = 1'b0,
    CHEER_RUN  = 1'b1
  } cheer_state_t;

endpackage

// File: rtl/cheer_pulse_sync.sv
// Synchroniser for the asynchronous is_victory level plus rising-edge one-pulse.
// sy_victory is the last synchroniser stage; win_game is high for one clk per 0->1 on it.
module cheer_pulse_sync
  import cheer_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic is_victory,
  output logic sy_victory,
  output logic win_game
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sy_d;

  // Shift the raw level through the chain and keep a one-clk-delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      sy_d   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], is_victory};
      sy_d   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sy_victory = sync_q[SYNC_STAGES-1];
  assign win_game   = sy_victory & ~sy_d;

endmodule

// File: rtl/cheer_victory.sv
// Victory-celebration path: synchronised win pulse starts a timed LED cheer of the latched score.
// Optional build macro CHEER_SWEEP_EN: the cheer rotates the score left once per slowen tick
// instead of blinking it; exit timing is the same in both builds.
module cheer_victory
  import cheer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CHEER_TICKS = 8,
  parameter int LED_W       = CHEER_LED_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slowen,
  input  logic             is_victory,
  input  logic [LED_W-1:0] score,
  output logic             sy_victory,
  output logic             win_game,
  output logic [LED_W-1:0] victory_led
);

  localparam int            CW       = $clog2(CHEER_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CHEER_TICKS - 1);

  cheer_state_t     state;
  logic [CW-1:0]    cnt;
  logic [LED_W-1:0] pattern;
`ifndef CHEER_SWEEP_EN
  logic             phase;
`endif

  cheer_pulse_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_pulse_sync (
    .clk       (clk),
    .rst       (rst),
    .is_victory(is_victory),
    .sy_victory(sy_victory),
    .win_game  (win_game)
  );

  // Cheer sequencer: a win pulse (re)starts the cheer; slowen ticks advance it until the last tick.
  // In sweep builds 'pattern' holds the currently displayed rotation; in blink builds the latched score.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= CHEER_IDLE;
      cnt         <= '0;
      pattern     <= '0;
      victory_led <= '0;
`ifndef CHEER_SWEEP_EN
      phase       <= 1'b0;
`endif
    end else if (win_game) begin
      state       <= CHEER_RUN;
      cnt         <= '0;
      pattern     <= score;
      victory_led <= score;
`ifndef CHEER_SWEEP_EN
      phase       <= 1'b0;
`endif
    end else if (state == CHEER_RUN && slowen) begin
      if (cnt == CNT_LAST) begin
        state       <= CHEER_IDLE;
        cnt         <= '0;
        victory_led <= '0;
`ifndef CHEER_SWEEP_EN
        phase       <= 1'b0;
`endif
      end else begin
        cnt <= cnt + 1'b1;
`ifdef CHEER_SWEEP_EN
        pattern     <= {pattern[LED_W-2:0], pattern[LED_W-1]};
        victory_led <= {pattern[LED_W-2:0], pattern[LED_W-1]};
`else
        // The new phase is ~phase: dark when it becomes 1, score when it returns to 0.
        phase       <= ~phase;
        victory_led <= phase ? pattern : '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cheer_victory.sv
// Scoreboard bench for cheer_victory: a per-edge reference model pushes expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_cheer_victory;

  localparam int SYNC_STAGES = 2;
  localparam int CHEER_TICKS = 8;
  localparam int LED_W       = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             slowen;
  logic             is_victory;
  logic [LED_W-1:0] score;
  logic             sy_victory;
  logic             win_game;
  logic [LED_W-1:0] victory_led;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [LED_W-1:0] led;
    logic             win;
    logic             sy;
  } exp_t;

  exp_t sb[$];

  cheer_victory #(
    .SYNC_STAGES(SYNC_STAGES),
    .CHEER_TICKS(CHEER_TICKS),
    .LED_W      (LED_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .slowen     (slowen),
    .is_victory (is_victory),
    .score      (score),
    .sy_victory (sy_victory),
    .win_game   (win_game),
    .victory_led(victory_led)
  );

  always #20 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
    end
  endtask

  function automatic logic [LED_W-1:0] rotl(input logic [LED_W-1:0] v, input int n);
    logic [LED_W-1:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[LED_W-2:0], r[LED_W-1]};
    return r;
  endfunction

  // Reference model: history of sampled is_victory levels, and a cheer described by
  // "started with score S, k slowen ticks elapsed".
  bit               hist[$];
  bit               win_now;
  bit               active;
  int               ticks;
  logic [LED_W-1:0] lsc;

  function automatic bit sy_after(input int e);
    // Level visible on sy_victory after edge e (1-based since reset release).
    if (e - SYNC_STAGES < 0) return 1'b0;
    return hist[e - SYNC_STAGES];
  endfunction

  always @(posedge clk) begin
    exp_t e;
    if (!rst) begin
      hist.delete();
      win_now = 1'b0;
      active  = 1'b0;
      ticks   = 0;
      lsc     = '0;
      e.led = '0; e.win = 1'b0; e.sy = 1'b0;
    end else begin
      hist.push_back(is_victory);
      if (win_now) begin
        active = 1'b1;
        ticks  = 0;
        lsc    = score;
      end else if (active && slowen) begin
        ticks++;
        if (ticks == CHEER_TICKS) active = 1'b0;
      end
      e.sy    = sy_after(hist.size());
      win_now = e.sy && !sy_after(hist.size() - 1);
      e.win   = win_now;
      if (!active) e.led = '0;
`ifdef CHEER_SWEEP_EN
      else e.led = rotl(lsc, ticks);
`else
      else e.led = (ticks % 2 == 1) ? '0 : lsc;
`endif
    end
    sb.push_back(e);
  end

  // Monitor: the DUT presents a fresh output set every cycle; compare mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("sy_victory", sy_victory, e.sy);
      chk("win_game", win_game, e.win);
      chk("victory_led", victory_led, e.led);
    end
  end

  task automatic drive(input logic iv, input logic sl, input logic [LED_W-1:0] sc, input int n);
    repeat (n) begin
      @(negedge clk);
      #5;
      is_victory = iv;
      slowen     = sl;
      score      = sc;
    end
  endtask

  initial begin
    logic iv;
    rst        = 1'b0;
    slowen     = 1'b0;
    is_victory = 1'b0;
    score      = '0;
    repeat (3) @(negedge clk);
    #5 rst = 1'b1;

    // Pulse, blink, exit, held level never re-fires; score changes while idle are ignored.
    drive(1'b0, 1'b1, 7'b0000111, 2);
    drive(1'b1, 1'b1, 7'b0000111, 16);
    drive(1'b1, 1'b1, 7'b0110011, 4);

    // Re-arm with a one-clk low, retrigger with slowen high on the win edge.
    drive(1'b0, 1'b1, 7'b1010101, 1);
    drive(1'b1, 1'b1, 7'b1010101, 4);

    // Gating mid-cheer.
    drive(1'b1, 1'b0, 7'b1010101, 5);
    drive(1'b1, 1'b1, 7'b1010101, 2);

    // Asynchronous reset mid-cheer: outputs clear without a clock edge.
    @(negedge clk);
    #5 rst = 1'b0;
    #1;
    chk("rst_victory_led", victory_led, 0);
    chk("rst_win_game", win_game, 0);
    chk("rst_sy_victory", sy_victory, 0);
    repeat (2) @(negedge clk);
    #5 rst = 1'b1;
    drive(1'b1, 1'b1, 7'b0000111, 12);

    // Random traffic, including retriggers mid-cheer.
    iv = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) iv = ~iv;
      drive(iv, ($urandom_range(0, 3) != 0), LED_W'($urandom), 1);
    end

    drive(1'b0, 1'b1, '0, 12);
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
